matrix_generate_nxn: RTL
========================

// Module: matrix_generate_nxn
// PURPOSE
//  Streaming NxN neighbourhood generator for the canny/filter pipelines; successor to the fixed 3x3 generator.
//  Generalises window size, pixel width and channel count.
//  Adds explicit row/column tracking and top/left border handling (zero or replicate).
//  Sits between the sensor/colour-convert stage and Sobel/Gaussian/NMS kernels; window bottom-right = newest pixel.
// PARAMETERS
//  DATA_WIDTH   8    bits per channel sample
//  CHANNELS     1    samples per pixel (1=Y, 3=RGB), packed ch0 in LSBs
//  IMG_WIDTH    640  active pixels per line (line-buffer depth)
//  IMG_HEIGHT   480  active lines per frame (row counter saturates here)
//  WIN          3    window size, odd, 3..7
//  BORDER_MODE  0    0 = zero-fill off-image taps, 1 = replicate nearest on-image tap
// PORTS
//  clk                 in   1                          pixel clock
//  rst                 in   1                          async reset, active-high
//  per_frame_vsync     in   1                          frame sync, rising edge = new frame
//  per_frame_href      in   1                          line active
//  per_frame_clken     in   1                          pixel valid
//  per_img_data        in   CHANNELS*DATA_WIDTH        input pixel
//  matrix_frame_vsync  out  1                          vsync delayed 2 clk
//  matrix_frame_href   out  1                          href delayed 2 clk
//  matrix_frame_clken  out  1                          clken delayed 2 clk
//  matrix_win          out  WIN*WIN*CHANNELS*DATA_WIDTH  window; tap (r,c) at index r*WIN+c, r0c0 = oldest/top-left
//  matrix_col          out  clog2(IMG_WIDTH)           column of newest pixel (tap r=WIN-1,c=WIN-1)
//  matrix_row          out  clog2(IMG_HEIGHT)          row of newest pixel
//  matrix_border       out  1                          1 when any tap is off-image (row<WIN-1 or col<WIN-1)
// BEHAVIOUR
//  Reset: all outputs 0; col/row counters 0; sync pipes 0. Line-RAM contents not cleared.
//  Line buffers: WIN-1 RAMs of IMG_WIDTH x (CHANNELS*DATA_WIDTH), chained.
//   - On clken&&href at column c: read-before-write, buffer k outputs line y-1-k at column c.
//  Cycle 1: line-buffer read + counter/sync register. Cycle 2: window shift into matrix_win.
//   - Shift occurs only on delayed clken&&href.
//   - Delayed href low -> matrix_win cleared to 0.
//  Latency: pixel at cycle t appears at tap (WIN-1,WIN-1) with matrix_frame_clken at t+2.
//  Column counter: reset to 0 on href falling edge; +1 per clken&&href.
//   - Saturates at IMG_WIDTH-1; pixels beyond are dropped (no RAM write, no shift).
//  Row counter: cleared on vsync rising edge; +1 on href falling edge; saturates at IMG_HEIGHT-1.
//  Border masking is applied on the cycle-2 register input:
//   - Taps with row<0 or col<0 are substituted.
//   - BORDER_MODE 0: substitute 0.
//   - BORDER_MODE 1: substitute the tap clamped to row 0 / col 0 of the current window.
//   - Top rows replicate image row 0; left cols replicate column 0 of the same row.
//  Simultaneous vsync rise and href fall: vsync clear wins (row=0).
//  clken low inside href: window, counters and outputs hold.
//  Reset mid-frame:
//   - Counters restart at 0, so stale RAM lines are masked as border until WIN-1 new lines have been written.
//   - No X propagation.
//  Channels are independent lanes sharing counters and masking.
// STRUCTURE
//  Shared header img_proc_defs.vh: BORDER_ZERO=0, BORDER_REPL=1, CLOG2 macro, tap index macro.
//  Sub-module line_buffer_ram:
//   - Single-clock, depth IMG_WIDTH, read-before-write, clock-enable port.
//   - Instantiated WIN-1 times via generate.
//  Top contains counters, sync pipes, generate-loop shift registers and the masking mux.
// TESTING
//  1. WIN=3, 8x4 ramp frame (pix = row*16+col), BORDER_MODE 0:
//     - At row 2, col 2 the window is {0x00,01,02,10,11,12,20,21,22}.
//     - At row 0, col 0 it is all zero except tap8=0x00, with border=1.
//  2. Same frame, BORDER_MODE 1: at row 0, col 1 the window is {00,00,01,00,00,01,00,00,01}, border=1.
//  3. WIN=5, CHANNELS=3, RGB ramp:
//     - Each channel window matches a per-lane golden model.
//     - Sync outputs equal inputs delayed exactly 2 clk.
//  4. clken toggling 1010 within href: window advances only on valid pixels; col increments by 1 per valid.
//  5. Line of IMG_WIDTH+4 pixels: col saturates at IMG_WIDTH-1, next line's windows uncorrupted.
//  6. Assert rst at row 3 col 5, release, restart frame:
//     - All outputs 0 during reset.
//     - First WIN-1 rows report border=1, and mode-0 upper taps are 0.

Source files
------------

// File: rtl/matrix_generate_nxn_pkg.sv
// Shared definitions for the NxN neighbourhood generator: border fill modes, sync bundle, tap indexing.
package matrix_generate_nxn_pkg;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // Flat tap position in the packed window: row-major, r0c0 = oldest/top-left.
  function automatic int tap_idx(input int r, input int c, input int win);
    return r * win + c;
  endfunction

endpackage

// File: rtl/matrix_generate_nxn_line_buffer_ram.sv
// One line of pixel history: registered read on rd_en, independent write port, old data on same-address collision.
// Latency 1 clk for reads; no flow control, the caller owns the enables.
module line_buffer_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

endmodule

// File: rtl/matrix_generate_nxn.sv
// Streaming WINxWIN neighbourhood generator with row/column tracking and top/left border fill.
// Latency 2 clk (line-RAM read, then window shift); no backpressure, pixels past IMG_WIDTH-1 are dropped.
module matrix_generate_nxn
  import matrix_generate_nxn_pkg::*;
#(
  parameter int  DATA_WIDTH  = 8,
  parameter int  CHANNELS    = 1,
  parameter int  IMG_WIDTH   = 640,
  parameter int  IMG_HEIGHT  = 480,
  parameter int  WIN         = 3,
  parameter int  BORDER_MODE = BORDER_ZERO,
  localparam int PW          = CHANNELS * DATA_WIDTH,
  localparam int CW          = $clog2(IMG_WIDTH),
  localparam int RW          = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [PW-1:0]         per_img_data,
  output logic                  matrix_frame_vsync,
  output logic                  matrix_frame_href,
  output logic                  matrix_frame_clken,
  output logic [WIN*WIN*PW-1:0] matrix_win,
  output logic [CW-1:0]         matrix_col,
  output logic [RW-1:0]         matrix_row,
  output logic                  matrix_border
);

  localparam int NB = WIN - 1;
  localparam bit REPLICATE = (BORDER_MODE == BORDER_REPL);

  sync_t         sync_in, sync_d1, sync_d2;
  logic [CW-1:0] col_cnt, s1_col;
  logic          col_full;
  logic [RW-1:0] row_cnt, s1_row;
  logic [PW-1:0] s1_pix;
  logic          s1_vld;
  logic          accept, href_fall, vsync_rise;

  logic [PW-1:0] lb_rd [NB];
  logic          lb_we [NB];
  logic [CW-1:0] lb_wa [NB];
  logic [PW-1:0] lb_wd [NB];

  logic [PW-1:0] raw_q   [WIN][WIN];
  logic [PW-1:0] raw_nxt [WIN][WIN];
  logic [PW-1:0] win_nxt [WIN][WIN];
  int            top_n, left_n, rr, cc;

  assign sync_in    = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
  assign accept     = per_frame_clken & per_frame_href & ~col_full;
  assign href_fall  = sync_d1.href & ~per_frame_href;
  assign vsync_rise = per_frame_vsync & ~sync_d1.vsync;

  // Buffer 0 takes the live pixel; deeper buffers take the previous buffer's read one cycle later,
  // which lands on the same column the read came from.
  for (genvar k = 0; k < NB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_we[k] = accept;
      assign lb_wa[k] = col_cnt;
      assign lb_wd[k] = per_img_data;
    end else begin : g_chain
      assign lb_we[k] = s1_vld;
      assign lb_wa[k] = s1_col;
      assign lb_wd[k] = lb_rd[k-1];
    end

    line_buffer_ram #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PW)
    ) u_lb (
      .clk     (clk),
      .rd_en   (accept),
      .rd_addr (col_cnt),
      .rd_dat  (lb_rd[k]),
      .wr_en   (lb_we[k]),
      .wr_addr (lb_wa[k]),
      .wr_dat  (lb_wd[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d1  <= '0;
      s1_vld   <= 1'b0;
      s1_pix   <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      col_cnt  <= '0;
      col_full <= 1'b0;
      row_cnt  <= '0;
    end else begin
      sync_d1 <= sync_in;
      s1_vld  <= accept;
      if (accept) begin
        s1_pix <= per_img_data;
        s1_col <= col_cnt;
        s1_row <= vsync_rise ? '0 : row_cnt;
        if (col_cnt == CW'(IMG_WIDTH - 1)) col_full <= 1'b1;
        else                               col_cnt  <= col_cnt + CW'(1);
      end
      if (href_fall) begin
        col_cnt  <= '0;
        col_full <= 1'b0;
      end
      if (vsync_rise)
        row_cnt <= '0;
      else if (href_fall && row_cnt != RW'(IMG_HEIGHT - 1))
        row_cnt <= row_cnt + RW'(1);
    end
  end

  // Raw window keeps unmasked history so replicate mode can clamp onto real on-image taps.
  always_comb begin
    top_n  = 0;
    left_n = 0;
    rr     = 0;
    cc     = 0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        raw_nxt[r][c] = raw_q[r][c];
    if (s1_vld) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN - 1; c++)
          raw_nxt[r][c] = raw_q[r][c+1];
      for (int r = 0; r < WIN - 1; r++)
        raw_nxt[r][WIN-1] = lb_rd[WIN-2-r];
      raw_nxt[WIN-1][WIN-1] = s1_pix;
    end

    if (int'(s1_row) < WIN - 1) top_n  = WIN - 1 - int'(s1_row);
    if (int'(s1_col) < WIN - 1) left_n = WIN - 1 - int'(s1_col);
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        rr = (r < top_n)  ? top_n  : r;
        cc = (c < left_n) ? left_n : c;
        if ((r < top_n || c < left_n) && !REPLICATE) win_nxt[r][c] = '0;
        else                                          win_nxt[r][c] = raw_nxt[rr][cc];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d2       <= '0;
      matrix_win    <= '0;
      matrix_col    <= '0;
      matrix_row    <= '0;
      matrix_border <= 1'b0;
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          raw_q[r][c] <= '0;
    end else begin
      sync_d2 <= sync_d1;
      if (s1_vld) begin
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++) begin
            raw_q[r][c] <= raw_nxt[r][c];
            matrix_win[tap_idx(r, c, WIN)*PW +: PW] <= win_nxt[r][c];
          end
        matrix_col    <= s1_col;
        matrix_row    <= s1_row;
        matrix_border <= (int'(s1_row) < WIN - 1) || (int'(s1_col) < WIN - 1);
      end else if (!sync_d1.href) begin
        matrix_win <= '0;
      end
    end
  end

  assign matrix_frame_vsync = sync_d2.vsync;
  assign matrix_frame_href  = sync_d2.href;
  assign matrix_frame_clken = sync_d2.clken;

endmodule
